led_blink_multi: RTL

//  Parametrised N-channel LED driver, successor to the single fixed-rate blinker.
//  One shared prescaler produces a base tick (1 ms at 50 MHz by default).

---
 rtl/led_pkg.sv | 17 +
 rtl/led_blink_multi_if.sv | 29 ++
 rtl/led_blink_multi_chan.sv | 65 ++++++
 rtl/led_blink_multi.sv | 61 ++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED driver: channel modes and
// the channel-index width helper used by the interface and the top level.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PULSE = 2'd3
    } led_mode_t;

    // A single channel still needs a one-bit index field.
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/led_blink_multi_if.sv
// Configuration write port and LED status outputs of the LED driver.
// The controller uses the master modport; the driver uses the slave modport.
interface led_blink_multi_if #(
    parameter int NCH   = 3,
    parameter int PER_W = 16
);
    import led_pkg::*;

    localparam int CH_W = ch_width(NCH);

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [1:0]       wr_mode;
    logic [PER_W-1:0] wr_period;
    logic [NCH-1:0]   led;
    logic [NCH-1:0]   busy;
    logic             tick;

    modport master (
        output wr_en, wr_ch, wr_mode, wr_period,
        input  led, busy, tick
    );

    modport slave (
        input  wr_en, wr_ch, wr_mode, wr_period,
        output led, busy, tick
    );

endinterface

// File: rtl/led_blink_multi_chan.sv
// One LED channel: holds its mode, period and tick counter, and produces the
// logical lit level plus a busy flag while a one-shot pulse is running.
module led_chan
    import led_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr,
    input  logic [1:0]       mode_in,
    input  logic [PER_W-1:0] period_in,
    output logic             lvl,
    output logic             busy
);

    led_mode_t        mode;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] last;

    // A programmed period of zero behaves like a period of one tick.
    assign last = (period == '0) ? '0 : period - 1'b1;

    // A write always wins over a coincident tick, so the new setting starts
    // its count cleanly from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= LED_OFF;
            period <= '0;
            cnt    <= '0;
            lvl    <= 1'b0;
        end else if (wr) begin
            mode   <= led_mode_t'(mode_in);
            period <= period_in;
            cnt    <= '0;
            lvl    <= (led_mode_t'(mode_in) != LED_OFF);
        end else if (tick) begin
            case (mode)
                LED_BLINK: begin
                    if (cnt == last) begin
                        cnt <= '0;
                        lvl <= ~lvl;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LED_PULSE: begin
                    if (cnt == last) begin
                        cnt  <= '0;
                        lvl  <= 1'b0;
                        mode <= LED_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign busy = (mode == LED_PULSE);

endmodule

// File: rtl/led_blink_multi.sv
// N-channel LED driver: a shared prescaler generates the base tick and each
// channel blinks or pulses in units of that tick, with optional pin inversion.
module led_blink_multi
    import led_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int TICK_DIV   = 50000,
    parameter int PER_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    led_blink_multi_if.slave bus
);

    localparam int CH_W  = ch_width(NCH);
    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] count;
    logic             tick_q;
    logic [NCH-1:0]   wr_vec;
    logic [NCH-1:0]   lvl;
    logic [NCH-1:0]   busy_vec;

    // The strobe is registered so every channel sees one clean clk-wide tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (count == PRE_W'(TICK_DIV - 1)) begin
            count  <= '0;
            tick_q <= 1'b1;
        end else begin
            count  <= count + 1'b1;
            tick_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Out-of-range channel indices match no channel and are dropped.
        assign wr_vec[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));

        led_chan #(
            .PER_W (PER_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick_q),
            .wr        (wr_vec[i]),
            .mode_in   (bus.wr_mode),
            .period_in (bus.wr_period),
            .lvl       (lvl[i]),
            .busy      (busy_vec[i])
        );
    end

    assign bus.led  = lvl ^ {NCH{ACTIVE_LOW != 0}};
    assign bus.busy = busy_vec;
    assign bus.tick = tick_q;

endmodule
